// File: rtl/ps2_keypad_decoder_if.sv
// rtl/ps2_keypad_decoder_if.sv - scan-code in / key-event out bundle for ps2_keypad_decoder
interface ps2_keypad_decoder_if;
  logic [7:0]  ps2_key_code;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [15:0] digits;
  logic        digit_valid;
  logic        load_time;
  logic        err;

  modport master (
    output ps2_key_code,
    input  key_valid, key_code, digits, digit_valid, load_time, err
  );

  modport slave (
    input  ps2_key_code,
    output key_valid, key_code, digits, digit_valid, load_time, err
  );
endinterface

// File: rtl/ps2_keypad_decoder.sv
// rtl/ps2_keypad_decoder.sv - make/F0/break decoder with BCD entry buffer; PS2_KEYPAD_CLEAR_EN adds KP_DOT clear
module ps2_keypad_decoder #(
  parameter int BRK_TIMEOUT = 1000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                ck,
  input  logic                reset_n,
  ps2_keypad_decoder_if.slave kp
);

  localparam int          DW          = 4 * NUM_DIGITS;
  localparam logic [19:0] BRK_LAST    = 20'(BRK_TIMEOUT - 1);
  localparam logic [7:0]  KP_RELEASED = 8'hF0;
  localparam logic [7:0]  KP_MINUS    = 8'h7B;
`ifdef PS2_KEYPAD_CLEAR_EN
  localparam logic [7:0]  KP_DOT      = 8'h71;
`endif

  typedef enum logic [1:0] {IDLE, MAKE, BRK} state_t;

  state_t          state;
  logic [7:0]      code_q;
  logic [7:0]      code_qq;
  logic [7:0]      latched;
  logic [7:0]      key_code_r;
  logic [DW-1:0]   digits_r;
  logic [19:0]     brk_cnt;
  logic            key_valid_r;
  logic            digit_valid_r;
  logic            load_time_r;
  logic            err_r;

  logic            new_code;
  logic            is_brk;
  logic            is_key;
  logic            is_digit;
  logic            is_minus;
  logic [3:0]      bcd;
`ifdef PS2_KEYPAD_CLEAR_EN
  logic            is_clear;
`endif

  // The level stream holds each code for many cycles; only a change is an event.
  assign new_code = (code_q != code_qq);
  assign is_brk   = (code_q == KP_RELEASED);

  // Classify the current code: digit (with its BCD value), load key, or not in the table.
  always_comb begin
    is_key   = 1'b1;
    is_digit = 1'b1;
    is_minus = 1'b0;
    bcd      = 4'd0;
`ifdef PS2_KEYPAD_CLEAR_EN
    is_clear = 1'b0;
`endif
    case (code_q)
      8'h70:    bcd = 4'd0;
      8'h69:    bcd = 4'd1;
      8'h72:    bcd = 4'd2;
      8'h7A:    bcd = 4'd3;
      8'h6B:    bcd = 4'd4;
      8'h73:    bcd = 4'd5;
      8'h74:    bcd = 4'd6;
      8'h6C:    bcd = 4'd7;
      8'h75:    bcd = 4'd8;
      8'h7D:    bcd = 4'd9;
      KP_MINUS: begin
        is_digit = 1'b0;
        is_minus = 1'b1;
      end
`ifdef PS2_KEYPAD_CLEAR_EN
      KP_DOT: begin
        is_digit = 1'b0;
        is_clear = 1'b1;
      end
`endif
      default: begin
        is_key   = 1'b0;
        is_digit = 1'b0;
      end
    endcase
  end

  // Input pipeline, make/break sequencer, break timeout and registered event pulses.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      code_q        <= 8'h00;
      code_qq       <= 8'h00;
      latched       <= 8'h00;
      key_code_r    <= 8'h00;
      digits_r      <= '0;
      brk_cnt       <= 20'd0;
      key_valid_r   <= 1'b0;
      digit_valid_r <= 1'b0;
      load_time_r   <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      code_q        <= kp.ps2_key_code;
      code_qq       <= code_q;
      key_valid_r   <= 1'b0;
      digit_valid_r <= 1'b0;
      load_time_r   <= 1'b0;
      err_r         <= 1'b0;
      case (state)
        IDLE: begin
          // A stray F0 here is a break without a make and is dropped silently.
          if (new_code && is_key) begin
            latched <= code_q;
            state   <= MAKE;
          end
        end
        MAKE: begin
          if (new_code && is_brk) begin
            brk_cnt <= 20'd0;
            state   <= BRK;
          end else if (new_code && is_key) begin
            // Rollover: the most recently pressed key is the one we wait to see released.
            latched <= code_q;
          end
        end
        BRK: begin
          // A key arriving on the same edge as the timeout wins over the timeout.
          if (new_code && is_key) begin
            state <= IDLE;
            if (code_q == latched) begin
              key_valid_r <= 1'b1;
              key_code_r  <= latched;
              if (is_digit) begin
                digits_r      <= {digits_r[DW-5:0], bcd};
                digit_valid_r <= 1'b1;
              end
              if (is_minus) begin
                load_time_r <= 1'b1;
              end
`ifdef PS2_KEYPAD_CLEAR_EN
              if (is_clear) begin
                digits_r      <= '0;
                digit_valid_r <= 1'b1;
              end
`endif
            end else begin
              err_r <= 1'b1;
            end
          end else if (brk_cnt == BRK_LAST) begin
            err_r <= 1'b1;
            state <= IDLE;
          end else begin
            brk_cnt <= brk_cnt + 20'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.key_valid   = key_valid_r;
  assign kp.key_code    = key_code_r;
  assign kp.digits      = digits_r;
  assign kp.digit_valid = digit_valid_r;
  assign kp.load_time   = load_time_r;
  assign kp.err         = err_r;

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// tb/tb_ps2_keypad_decoder.sv - directed and randomized checks of ps2_keypad_decoder against an event-level model
module tb_ps2_keypad_decoder;

  localparam int T = 100;

  logic ck = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  ps2_keypad_decoder_if kp();

  ps2_keypad_decoder #(.BRK_TIMEOUT(T), .NUM_DIGITS(4)) dut (
    .ck      (ck),
    .reset_n (reset_n),
    .kp      (kp)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [27:0] obs_q[$];
  logic [27:0] exp_q[$];
  int          obs_cyc[$];

  wire [27:0] obs_now = {kp.key_valid, kp.digit_valid, kp.load_time, kp.err,
                         kp.key_code, kp.digits};

  // Record every cycle carrying any pulse, with its cycle stamp.
  always @(negedge ck) begin
    if (obs_now[27:24] != 4'b0000) begin
      obs_q.push_back(obs_now);
      obs_cyc.push_back(cyc);
    end
  end

  logic [7:0] kp_tab [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] keys   [12] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D, 8'h7B, 8'h71};

  // Reference model: what a user pressed, seen as a sequence of distinct codes.
  int          m_pend;
  bit          m_brk;
  int          m_brk_c;
  logic [7:0]  m_last;
  logic [7:0]  m_prev;
  logic [15:0] m_dig;
  int          last_drv;

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++)
      if (kp_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic bit is_table_key(input logic [7:0] c);
    bit k;
    k = (digit_of(c) >= 0) || (c == 8'h7B);
`ifdef PS2_KEYPAD_CLEAR_EN
    if (c == 8'h71) k = 1'b1;
`endif
    return k;
  endfunction

  task automatic model_reset();
    m_pend = -1; m_brk = 0; m_brk_c = 0;
    m_last = 8'h00; m_prev = 8'h00; m_dig = 16'h0000;
  endtask

  task automatic model_err();
    exp_q.push_back({4'b0001, m_last, m_dig});
  endtask

  task automatic model_commit(input logic [7:0] c);
    int d;
    m_last = c;
    d = digit_of(c);
    if (d >= 0) begin
      m_dig = {m_dig[11:0], 4'(d)};
      exp_q.push_back({4'b1100, c, m_dig});
    end else if (c == 8'h7B) begin
      exp_q.push_back({4'b1010, c, m_dig});
    end else begin
      m_dig = 16'h0000;
      exp_q.push_back({4'b1100, c, m_dig});
    end
  endtask

  // A release left waiting longer than T cycles before the next key is an abort.
  task automatic model_flush(input int now);
    if (m_brk && (now - m_brk_c > T)) begin
      model_err();
      m_brk  = 0;
      m_pend = -1;
    end
  endtask

  task automatic model_code(input logic [7:0] c, input int now);
    if (c == m_prev) return;
    m_prev = c;
    model_flush(now);
    if (c == 8'hF0) begin
      if (m_pend >= 0 && !m_brk) begin
        m_brk   = 1;
        m_brk_c = now;
      end
    end else if (is_table_key(c)) begin
      if (m_brk) begin
        if (c == 8'(m_pend)) model_commit(c);
        else                 model_err();
        m_brk  = 0;
        m_pend = -1;
      end else begin
        m_pend = int'(c);
      end
    end
  endtask

  task automatic check_v(input string tag, input logic [27:0] o, input logic [27:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_i(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic drive(input logic [7:0] c, input int hold);
    kp.ps2_key_code = c;
    last_drv = cyc;
    model_code(c, cyc);
    repeat (hold) @(posedge ck);
    #1;
  endtask

  task automatic settle();
    drive(8'h00, T + 5);
    model_flush(cyc);
    repeat (3) @(posedge ck);
    #1;
  endtask

  task automatic compare_events(input string tag);
    check_i({tag, " event count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_v({tag, " event"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int lc;
    int fc;
    int first_cyc;
    logic [7:0] k;
    logic [7:0] k2;

    kp.ps2_key_code = 8'h00;
    model_reset();
    repeat (3) @(posedge ck);
    #1;
    check_v("reset state", obs_now, 28'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge ck);
    #1;

    // Single digit 1 with long holds; pulse lands two cycles after the final code.
    drive(8'h69, 50);
    drive(8'hF0, 50);
    drive(8'h69, 50);
    lc = last_drv;
    first_cyc = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
    check_i("commit latency", first_cyc, lc + 2);
    settle();
    compare_events("first key");
    check_v("digits 0001", {12'h0, kp.digits}, 28'h0001);

    // Three more digits separated by gap codes.
    drive(8'h00, 4);
    drive(8'h72, 6); drive(8'hF0, 6); drive(8'h72, 6); drive(8'h00, 6);
    drive(8'h7A, 6); drive(8'hF0, 6); drive(8'h7A, 6); drive(8'h00, 6);
    drive(8'h6B, 6); drive(8'hF0, 6); drive(8'h6B, 6);
    settle();
    compare_events("digit run");
    check_v("digits 1234", {12'h0, kp.digits}, 28'h1234);

    // Load-time key leaves the buffer alone.
    drive(8'h7B, 8); drive(8'hF0, 8); drive(8'h7B, 8);
    settle();
    compare_events("kp minus");
    check_v("digits after minus", {12'h0, kp.digits}, 28'h1234);

    // Mismatched break, then a clean 2.
    drive(8'h69, 8); drive(8'hF0, 8); drive(8'h72, 8);
    drive(8'h00, 4);
    drive(8'h72, 8); drive(8'hF0, 8); drive(8'h72, 8);
    settle();
    compare_events("mismatch");
    check_v("digits 2342", {12'h0, kp.digits}, 28'h2342);

    // Break timeout, then a fresh 1.
    drive(8'h69, 8);
    drive(8'hF0, T + 50);
    fc = last_drv;
    first_cyc = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
    check_i("timeout cycle", first_cyc, fc + 2 + T);
    drive(8'h69, 8); drive(8'hF0, 8); drive(8'h69, 8);
    settle();
    compare_events("timeout");
    check_v("digits 3421", {12'h0, kp.digits}, 28'h3421);

    // Reset in the middle of a break discards the sequence.
    drive(8'h6B, 5);
    drive(8'hF0, 5);
    reset_n = 1'b0;
    #1;
    check_v("async reset outputs", obs_now, 28'h0);
    kp.ps2_key_code = 8'h00;
    model_reset();
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    repeat (3) @(posedge ck);
    #1;
    reset_n = 1'b1;
    drive(8'hF0, 6);
    drive(8'h69, 6);
    settle();
    compare_events("after reset");
    check_v("digits after reset", {12'h0, kp.digits}, 28'h0000);

    // Randomized press patterns, including releases held right around the timeout.
    for (int g = 0; g < 200; g++) begin
      k  = keys[$urandom_range(0, 11)];
      k2 = keys[$urandom_range(0, 11)];
      case ($urandom_range(0, 4))
        0, 1: begin
          drive(k, $urandom_range(1, 10)); drive(8'hF0, $urandom_range(1, 10)); drive(k, $urandom_range(1, 10));
        end
        2: begin
          drive(k, $urandom_range(1, 10)); drive(8'hF0, $urandom_range(1, 10)); drive(k2, $urandom_range(1, 10));
        end
        3: begin
          drive(k, $urandom_range(1, 10)); drive(k2, $urandom_range(1, 10));
          drive(8'hF0, $urandom_range(1, 10)); drive(k2, $urandom_range(1, 10));
        end
        default: begin
          drive(k, $urandom_range(1, 10)); drive(8'hF0, $urandom_range(T - 3, T + 3)); drive(k, $urandom_range(1, 10));
        end
      endcase
      if ($urandom_range(0, 1) == 1) drive(8'h00, $urandom_range(1, 10));
      if (g % 25 == 24) begin
        settle();
        compare_events("random");
        check_v("random digits", {12'h0, kp.digits}, {12'h0, m_dig});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
